// File: rtl/theremin_filter_pkg.sv
// Shared types and constants for the filter sample decimator.
// The FILTER_DECIM_TIMESTAMP_EN macro adds a timestamp field to each FIFO entry.
package theremin_filter_pkg;

  localparam int DATA_BITS_DEF = 30;
  localparam int TS_BITS_DEF   = 32;
  localparam int OVF_BITS_DEF  = 16;

  // Value the overflow counter sticks at once it saturates (default width).
  localparam logic [OVF_BITS_DEF-1:0] OVF_SAT_DEF = '1;

  // One FIFO entry at default widths: sample value plus optional timestamp.
  typedef struct packed {
`ifdef FILTER_DECIM_TIMESTAMP_EN
    logic [TS_BITS_DEF-1:0]   ts;
`endif
    logic [DATA_BITS_DEF-1:0] value;
  } fifo_entry_t;

  // Width of a packed FIFO entry for arbitrary data/timestamp widths.
  function automatic int entry_bits(input int data_bits, input int ts_bits, input bit ts_en);
    return ts_en ? data_bits + ts_bits : data_bits;
  endfunction

endpackage

// File: rtl/filter_sample_fifo.sv
// Small synchronous FIFO for captured filter samples.
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
module filter_sample_fifo #(
  parameter int WIDTH      = 30,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam logic [DEPTH_LOG2:0] PTR_MSB = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH_LOG2:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [AW-1:0]       waddr, raddr;
  logic                do_push, do_pop;

  if (DEPTH_LOG2 == 0) begin : g_single
    assign waddr = '0;
    assign raddr = '0;
  end else begin : g_multi
    assign waddr = wr_q[AW-1:0];
    assign raddr = rd_q[AW-1:0];
  end

  assign empty   = (wr_q == rd_q);
  assign full    = ((wr_q ^ rd_q) == PTR_MSB);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[raddr];

  // Next pointer values: each side advances by one on an accepted transfer.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (DEPTH_LOG2 + 1)'(1);
    if (do_pop)  rd_d = rd_q + (DEPTH_LOG2 + 1)'(1);
  end

  // Pointer registers, cleared asynchronously so the FIFO empties instantly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[waddr] <= din;
  end

endmodule

// File: rtl/filter_sample_decimator.sv
// Decimating reader for the IIR filter chain: captures every Nth CE sample,
// queues it, and streams it out over valid/ready while counting drops.
// Define FILTER_DECIM_TIMESTAMP_EN to tag each sample with a cycle timestamp.
module filter_sample_decimator
  import theremin_filter_pkg::*;
#(
  parameter int DATA_BITS       = DATA_BITS_DEF,
  parameter int DECIM_BITS      = 8,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int OVF_BITS        = OVF_BITS_DEF,
  parameter int TS_BITS         = TS_BITS_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CE,
  input  logic [DATA_BITS-1:0]  IN_VALUE,
  input  logic [DECIM_BITS-1:0] DECIM_RATIO,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_BITS-1:0]  OUT_VALUE,
  output logic [OVF_BITS-1:0]   OVF_COUNT,
`ifdef FILTER_DECIM_TIMESTAMP_EN
  output logic [TS_BITS-1:0]    OUT_TIMESTAMP,
`endif
  input  logic                  CLR_OVF
);

`ifdef FILTER_DECIM_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int ENTRY_BITS = entry_bits(DATA_BITS, TS_BITS, TS_EN);

  logic [DECIM_BITS-1:0] cnt_q, cnt_d;
  logic [OVF_BITS-1:0]   ovf_q, ovf_d;
  logic                  capture, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [ENTRY_BITS-1:0] fifo_din, fifo_dout;

  // Decimation: a CE with the counter at or past the ratio captures and restarts.
  always_comb begin
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (CE) begin
      if (cnt_q >= DECIM_RATIO) begin
        capture = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + DECIM_BITS'(1);
      end
    end
  end

  assign OUT_VALID = ~fifo_empty;
  assign pop       = OUT_VALID & OUT_READY;
  assign drop      = capture & fifo_full & ~pop;

  // Overflow count: clear takes priority, then a same-cycle drop counts once.
  always_comb begin
    ovf_d = ovf_q;
    if (CLR_OVF) begin
      ovf_d = drop ? OVF_BITS'(1) : '0;
    end else if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_BITS'(1);
    end
  end

  // Decimation counter and overflow counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign OVF_COUNT = ovf_q;

`ifdef FILTER_DECIM_TIMESTAMP_EN
  logic [TS_BITS-1:0] ts_q;

  // Free-running cycle counter sampled alongside each captured value.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ts_q <= '0;
    else          ts_q <= ts_q + TS_BITS'(1);
  end

  assign fifo_din      = {ts_q, IN_VALUE};
  assign OUT_VALUE     = fifo_dout[DATA_BITS-1:0];
  assign OUT_TIMESTAMP = fifo_dout[ENTRY_BITS-1:DATA_BITS];
`else
  assign fifo_din  = IN_VALUE;
  assign OUT_VALUE = fifo_dout;
`endif

  filter_sample_fifo #(
    .WIDTH      (ENTRY_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (capture),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_filter_sample_decimator.sv
// Randomised and directed bench for filter_sample_decimator, checked against a
// queue-based reference model. Compile with FILTER_DECIM_TIMESTAMP_EN to also
// check timestamps.
module tb_filter_sample_decimator;
  import theremin_filter_pkg::*;

  localparam int DEPTH   = 4;
  localparam int OVF_MAX = 65535;

  logic        CLK;
  logic        RESET_N;
  logic        CE;
  logic [29:0] IN_VALUE;
  logic [7:0]  DECIM_RATIO;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [29:0] OUT_VALUE;
  logic [15:0] OVF_COUNT;
  logic        CLR_OVF;
`ifdef FILTER_DECIM_TIMESTAMP_EN
  logic [31:0] OUT_TIMESTAMP;
`endif

  filter_sample_decimator dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .CE            (CE),
    .IN_VALUE      (IN_VALUE),
    .DECIM_RATIO   (DECIM_RATIO),
    .OUT_VALID     (OUT_VALID),
    .OUT_READY     (OUT_READY),
    .OUT_VALUE     (OUT_VALUE),
    .OVF_COUNT     (OVF_COUNT),
`ifdef FILTER_DECIM_TIMESTAMP_EN
    .OUT_TIMESTAMP (OUT_TIMESTAMP),
`endif
    .CLR_OVF       (CLR_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec;
  int n_err;

  // Reference model state: queued samples, their timestamps, counters.
  int unsigned   m_cnt;
  int unsigned   m_ovf;
  int unsigned   m_cycle;
  logic [29:0]   m_q[$];
  logic [31:0]   m_ts[$];
  logic [29:0]   popped[$];

  task automatic model_reset();
    m_cnt   = 0;
    m_ovf   = 0;
    m_cycle = 0;
    m_q.delete();
    m_ts.delete();
    popped.delete();
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    bit pop, cap, full, drop;
    pop  = (m_q.size() > 0) && OUT_READY;
    cap  = CE && (m_cnt >= DECIM_RATIO);
    full = (m_q.size() == DEPTH);
    drop = cap && full && !pop;
    if (OUT_VALID && OUT_READY) popped.push_back(OUT_VALUE);
    if (CE) m_cnt = cap ? 0 : m_cnt + 1;
    if (pop) begin
      void'(m_q.pop_front());
      void'(m_ts.pop_front());
    end
    if (cap && !drop) begin
      m_q.push_back(IN_VALUE);
      m_ts.push_back(m_cycle);
    end
    if (CLR_OVF) m_ovf = drop ? 1 : 0;
    else if (drop && m_ovf < OVF_MAX) m_ovf = m_ovf + 1;
    m_cycle = m_cycle + 1;
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input bit ce, input logic [29:0] val, input logic [7:0] ratio,
                               input bit ready, input bit clr);
    CE          = ce;
    IN_VALUE    = val;
    DECIM_RATIO = ratio;
    OUT_READY   = ready;
    CLR_OVF     = clr;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, '0, 8'd0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    applyStimulus(1'b1, 30'h155, 8'd0, 1'b0, 1'b0);
    step();
    step();
    RESET_N = 1'b0;
    #1;
    n_vec++;
    if (OUT_VALID !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_valid got %b want 0", OUT_VALID);
    end
    n_vec++;
    if (OUT_VALUE !== 30'd0) begin
      n_err++; $display("[TB] FAIL reset_value got %h want 0", OUT_VALUE);
    end
    n_vec++;
    if (OVF_COUNT !== 16'd0) begin
      n_err++; $display("[TB] FAIL reset_ovf got %0d want 0", OVF_COUNT);
    end
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 30'(i), 8'd3, 1'b1, 1'b0);
      n_vec++;
      if (OUT_VALID !== (m_q.size() != 0)) begin
        n_err++; $display("[TB] FAIL ramp_valid cyc %0d got %b want %b", i, OUT_VALID, m_q.size() != 0);
      end
      step();
    end
    n_vec++;
    if (popped.size() != 3 || popped[0] !== 30'd3 || popped[1] !== 30'd7 || popped[2] !== 30'd11) begin
      n_err++; $display("[TB] FAIL ramp_captures got %p want 3,7,11", popped);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 30'(100 + i), 8'd0, 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, '0, 8'd0, 1'b0, 1'b0);
    n_vec++;
    if (OVF_COUNT !== 16'd2) begin
      n_err++; $display("[TB] FAIL ovf_count got %0d want 2", OVF_COUNT);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (OUT_VALID !== 1'b1 || OUT_VALUE !== 30'd100) begin
        n_err++; $display("[TB] FAIL ovf_hold got %b/%0d want 1/100", OUT_VALID, OUT_VALUE);
      end
      step();
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_vec++;
    if (popped.size() != 4 || popped[0] !== 30'd100 || popped[1] !== 30'd101 ||
        popped[2] !== 30'd102 || popped[3] !== 30'd103) begin
      n_err++; $display("[TB] FAIL ovf_drain got %p want 100..103", popped);
    end
    n_vec++;
    if (OUT_VALID !== 1'b0) begin
      n_err++; $display("[TB] FAIL ovf_empty got %b want 0", OUT_VALID);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 30'(200 + i), 8'd0, 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 30'd250, 8'd0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, '0, 8'd0, 1'b0, 1'b0);
    n_vec++;
    if (OVF_COUNT !== 16'd0) begin
      n_err++; $display("[TB] FAIL b2b_ovf got %0d want 0", OVF_COUNT);
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_vec++;
    if (popped.size() != 5 || popped[0] !== 30'd200 || popped[1] !== 30'd201 ||
        popped[2] !== 30'd202 || popped[3] !== 30'd203 || popped[4] !== 30'd250) begin
      n_err++; $display("[TB] FAIL b2b_order got %p want 200..203,250", popped);
    end
  endtask

  task automatic test_ratio_change();
    int ce_idx;
    do_reset();
    ce_idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1'b1, 30'(ce_idx), (ce_idx < 7) ? 8'd10 : 8'd2, 1'b1, 1'b0);
        ce_idx++;
      end else begin
        applyStimulus(1'b0, 30'h3FFFFFFF, 8'd2, 1'b1, 1'b0);
      end
      step();
    end
    n_vec++;
    if (popped.size() < 3 || popped[0] !== 30'd7 || popped[1] !== 30'd10 || popped[2] !== 30'd13) begin
      n_err++; $display("[TB] FAIL ratio_change got %p want 7,10,13,...", popped);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    applyStimulus(1'b1, 30'h1234, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < OVF_MAX + DEPTH + 2; i++) step();
    n_vec++;
    if (OVF_COUNT !== OVF_SAT_DEF) begin
      n_err++; $display("[TB] FAIL sat_reach got %h want %h", OVF_COUNT, OVF_SAT_DEF);
    end
    step();
    n_vec++;
    if (OVF_COUNT !== OVF_SAT_DEF) begin
      n_err++; $display("[TB] FAIL sat_hold got %h want %h", OVF_COUNT, OVF_SAT_DEF);
    end
    CLR_OVF = 1'b1;
    step();
    n_vec++;
    if (OVF_COUNT !== 16'd1) begin
      n_err++; $display("[TB] FAIL clr_with_drop got %0d want 1", OVF_COUNT);
    end
    CE = 1'b0;
    step();
    n_vec++;
    if (OVF_COUNT !== 16'd0) begin
      n_err++; $display("[TB] FAIL clr_only got %0d want 0", OVF_COUNT);
    end
  endtask

  task automatic test_async_reset();
    int first;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 30'(300 + i), 8'd0, 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, '0, 8'd0, 1'b0, 1'b0);
    n_vec++;
    if (OUT_VALID !== 1'b1) begin
      n_err++; $display("[TB] FAIL areset_pre got %b want 1", OUT_VALID);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    n_vec++;
    if (OUT_VALID !== 1'b0 || OUT_VALUE !== 30'd0) begin
      n_err++; $display("[TB] FAIL areset_immediate got %b/%h want 0/0", OUT_VALID, OUT_VALUE);
    end
    #3;
    RESET_N = 1'b1;
    model_reset();
    applyStimulus(1'b1, 30'd77, 8'd2, 1'b0, 1'b0);
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (first < 0 && OUT_VALID === 1'b1) first = i;
    end
    n_vec++;
    if (first != 3) begin
      n_err++; $display("[TB] FAIL areset_first_capture got %0d want 3", first);
    end
`ifdef FILTER_DECIM_TIMESTAMP_EN
    n_vec++;
    if (OUT_TIMESTAMP !== 32'd2) begin
      n_err++; $display("[TB] FAIL areset_timestamp got %0d want 2", OUT_TIMESTAMP);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] ratio;
    do_reset();
    ratio = 8'd1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) ratio = 8'($urandom_range(0, 4));
      applyStimulus($urandom_range(0, 2) != 0, 30'($urandom), ratio,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
      n_vec++;
      if (OUT_VALID !== (m_q.size() != 0)) begin
        n_err++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", i, OUT_VALID, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        n_vec++;
        if (OUT_VALUE !== m_q[0]) begin
          n_err++; $display("[TB] FAIL rnd_value cyc %0d got %h want %h", i, OUT_VALUE, m_q[0]);
        end
`ifdef FILTER_DECIM_TIMESTAMP_EN
        n_vec++;
        if (OUT_TIMESTAMP !== m_ts[0]) begin
          n_err++; $display("[TB] FAIL rnd_ts cyc %0d got %0d want %0d", i, OUT_TIMESTAMP, m_ts[0]);
        end
`endif
      end
      n_vec++;
      if (OVF_COUNT !== 16'(m_ovf)) begin
        n_err++; $display("[TB] FAIL rnd_ovf cyc %0d got %0d want %0d", i, OVF_COUNT, m_ovf);
      end
      step();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    applyStimulus(1'b0, '0, 8'd0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    test_reset();
    test_ramp();
    test_overflow();
    test_back_to_back();
    test_ratio_change();
    test_async_reset();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
